// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// The line is oversampled at CLKS_PER_BIT system clocks per bit; each bit is
// sampled at mid-bit and a good byte is presented with a one-cycle strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_dv_q,   rx_dv_d;
    logic [1:0]       sync_q;
    logic             rx_s;

    // Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value,
            // so the two stages really are two cycles deep.
            sync_q <= {sync_q[0], i_rx_serial};
        end
    end

    assign rx_s = sync_q[1];

    // State, counters, shift register and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            rx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

    // Next-state logic: start-bit qualification, mid-bit data sampling, stop check.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    // Line back high at mid start bit means it was only a glitch.
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    // A low stop bit is a framing error: drop the byte silently.
                    if (rx_s) begin
                        rx_byte_d = shift_q;
                        rx_dv_d   = 1'b1;
                    end
                    state_d = CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            CLEANUP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rx_dv   = rx_dv_q;
    assign o_rx_byte = rx_byte_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks the received bytes
// against a scoreboard of expected values.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk;
    logic       rst;
    logic       rx_line;
    logic       rx_dv;
    logic [7:0] rx_byte;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_serial (rx_line),
        .o_rx_dv     (rx_dv),
        .o_rx_byte   (rx_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         gap;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    int         strobes = 0;
    int         exp_strobes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_dv = 1'b0;
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rx_dv) begin
            strobes++;
            check("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {24'd0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
                check("strobe_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_dv = rx_dv;
    end

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int gap);
        if (stop_ok) begin
            exp_q.push_back(data);
            exp_strobes++;
            last_good = data;
        end
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop_ok ? 1'b1 : 1'b0);
        idle(gap);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        rx_line = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dv", {31'd0, rx_dv}, 0);
        check("reset_byte", {24'd0, rx_byte}, 0);
        rst = 1'b0;
        idle(20);

        // Vector table: single byte, header + payload, back-to-back, framing error.
        vecs.push_back('{8'hAA, 1'b1, 100});
        vecs.push_back('{8'hAA, 1'b1, 10 * CPB});
        for (int i = 0; i < 32; i++) begin
            vecs.push_back('{(i == 10) ? 8'h20 : 8'h00, 1'b1, 10 * CPB});
        end
        vecs.push_back('{8'h55, 1'b1, 0});
        vecs.push_back('{8'h01, 1'b1, 0});
        vecs.push_back('{8'h80, 1'b1, 0});
        vecs.push_back('{8'hFF, 1'b1, 100});
        vecs.push_back('{8'h12, 1'b1, 100});
        vecs.push_back('{8'h34, 1'b0, 100});

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
            // Strobe for a frame lands before its stop bit ends, so these hold here.
            check("held_byte", {24'd0, rx_byte}, {24'd0, last_good});
            check("strobe_count", strobes, exp_strobes);
        end
        wait_drain();

        // Short low glitch on an idle line must not start a frame.
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        idle(50);
        check("glitch_no_strobe", strobes, exp_strobes);
        send_frame(8'h3C, 1'b1, 100);
        check("after_glitch_byte", {24'd0, rx_byte}, 32'h3C);
        check("after_glitch_count", strobes, exp_strobes);

        // Reset asserted mid-frame during data bit 4 of 0x5A.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        rx_line = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_dv", {31'd0, rx_dv}, 0);
        check("async_reset_byte", {24'd0, rx_byte}, 0);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(60);
        check("post_reset_no_strobe", strobes, exp_strobes);
        check("post_reset_byte", {24'd0, rx_byte}, 0);
        send_frame(8'hC3, 1'b1, 100);
        wait_drain();
        check("final_byte", {24'd0, rx_byte}, 32'hC3);
        check("final_count", strobes, exp_strobes);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. It oversamples the incoming line with the system clock at a fixed `CLKS_PER_BIT` ratio and presents each good byte with a one-cycle valid strobe. It sits at the front of the UART link and feeds a byte-stream consumer, e.g. a header-plus-image-payload parser.

## Interface
- `CLKS_PER_BIT`, default 87: system clocks per bit period. Legal range is ≥ 4. Benches use 10.
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, asynchronous and active-high; clears all state.
- `i_rx_serial`  in  1  serial line, asynchronous to `i_clk`, idle = 1.
- `o_rx_dv`  out  1  one-cycle strobe; a good byte is on `o_rx_byte`.
- `o_rx_byte`  out  8  last correctly received byte.

## Operation
- `i_rx_serial` passes through a 2-flop synchronizer, reset value 1. All FSM decisions use the synchronized bit `rx_s`.
- Bit counter `clk_cnt` has width `$clog2(CLKS_PER_BIT)`. Bit index `bit_idx` is 3 bits.
- FSM states: IDLE, START, DATA, STOP, CLEANUP.
- IDLE: `clk_cnt` = 0 and `bit_idx` = 0. On `rx_s` = 0, go to START.
- START: count up. When `clk_cnt` == (`CLKS_PER_BIT`-1)/2 (integer division), check the line:
  - `rx_s` = 0: clear `clk_cnt`, go to DATA.
  - `rx_s` = 1: glitch; go to IDLE with no output.
- DATA: count up. When `clk_cnt` == `CLKS_PER_BIT`-1, clear `clk_cnt` and store `rx_s` into shift-register bit `bit_idx` (LSB first).
  - `bit_idx` == 7: clear `bit_idx`, go to STOP.
  - Otherwise: increment `bit_idx`.
- STOP: count up. When `clk_cnt` == `CLKS_PER_BIT`-1, clear `clk_cnt` and check the stop bit:
  - `rx_s` = 1: load `o_rx_byte` from the shift register and assert `o_rx_dv` for the next cycle.
  - `rx_s` = 0: framing error; byte discarded, no strobe, `o_rx_byte` unchanged.
  - Either way, go to CLEANUP.
- CLEANUP: one cycle; deassert `o_rx_dv`; go to IDLE.
- `o_rx_byte` holds its value until the next good frame. It never changes without `o_rx_dv`.
- Byte values are not interpreted. 0x00 and 0xAA are ordinary data.
- Reset mid-frame: the FSM returns to IDLE immediately, outputs clear, and the partial byte is lost. The next falling edge after release starts a fresh frame.

## Timing
- Reset values: `o_rx_dv` = 0, `o_rx_byte` = 0x00, FSM = IDLE, synchronizer = 1.
- Each sample lands at mid-bit, (`CLKS_PER_BIT`-1)/2 clocks after the bit edge, plus 2 cycles of synchronizer delay.
- `o_rx_dv` rises ≈ 2 + (`CLKS_PER_BIT`-1)/2 + 9·`CLKS_PER_BIT` + 1 clocks after the start-bit falling edge. For `CLKS_PER_BIT` = 10 this is about 97 clocks.
- `o_rx_dv` is high for exactly 1 cycle per good frame.
- The FSM re-enters IDLE 2 cycles after the stop-bit sample, i.e. before the stop bit ends. Frames sent back-to-back with zero idle gap are all received.
- A low pulse shorter than (`CLKS_PER_BIT`-1)/2 clocks on an idle line produces no strobe.
- A break condition (line held low) produces framing errors with no strobes. The receiver resyncs on the next high-to-low transition after the line returns high.

## Test plan
- `CLKS_PER_BIT` = 10; reset, then hold the line idle 20 cycles; send 0xAA with a 100-cycle inter-byte gap -> exactly one `o_rx_dv` pulse, `o_rx_byte` = 0xAA, and `o_rx_byte` holds afterwards.
- Send header 0xAA, then 32 payload bytes, all 0x00 except payload[10] = 0x20, each followed by a 10-bit-time gap -> 33 strobes, byte 0 = 0xAA, byte 11 = 0x20, all others 0x00.
- Send 0x55, 0x01, 0x80, 0xFF with zero gap between frames -> 4 strobes in order with exactly those values. This checks bit order and back-to-back handling.
- Drive a 3-cycle low glitch on an idle line, then send 0x3C -> no strobe from the glitch; one strobe with 0x3C.
- Send 0x12 correctly, then send a frame with data 0x34 and stop bit 0 -> one strobe only (0x12); `o_rx_byte` stays 0x12.
- Assert `i_rst` during data bit 4 of a frame, release, then send 0xC3 -> `o_rx_dv` and `o_rx_byte` go to 0 asynchronously; the only strobe afterwards is 0xC3.
